pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register replacing the fixed per-stage registers (fetch-decode, decode-execute, execute-memory, memory-writeback).
- Carries a control bundle and a data bundle between stages with a valid/ready handshake, a synchronous flush, and a one-entry skid buffer.
- The skid buffer lets upstream ready be a pure register output, so no combinational ready path crosses stages.
- Flush turns the stage into a bubble by zeroing control fields, which suppresses regWrite/memWrite/branch/jump downstream.

---
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Parametrised pipeline stage register. It moves a control bundle
//            and a data bundle between stages using a valid/ready handshake.
//            It supports a synchronous flush (clr) and an optional one-entry
//            skid buffer, so that upstream ready comes straight from a register.
//            Optional feature macro PIPE_STAGE_PERF_EN adds saturating
//            stall/bubble performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int CTRL_W    = 19,
    parameter int DATA_W    = 175,
    parameter int SKID_EN_P = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    // Main entry: this entry always drives the stage outputs.
    logic              r_m_v;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic [DATA_W-1:0] r_m_data;

    logic w_accept;
    logic w_emit;

    assign w_accept  = in_valid & in_ready;
    assign w_emit    = r_m_v & out_ready;

    // Gate the control bundle with valid, so a bubble never carries stale control.
    assign out_valid = r_m_v;
    assign out_ctrl  = r_m_v ? r_m_ctrl : '0;
    assign out_data  = r_m_data;

    generate
        if (SKID_EN_P != 0) begin : g_skid
            // Skid entry: it catches the entry accepted while downstream stalls.
            logic              r_s_v;
            logic [CTRL_W-1:0] r_s_ctrl;
            logic [DATA_W-1:0] r_s_data;

            // Ready depends only on skid occupancy. No path from out_ready.
            assign in_ready = ~r_s_v;

            // Two-entry occupancy control (EMPTY / BUSY / FULL from m_v, s_v).
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_m_v    <= 1'b0;
                    r_m_ctrl <= '0;
                    r_m_data <= '0;
                    r_s_v    <= 1'b0;
                    r_s_ctrl <= '0;
                    r_s_data <= '0;
                end else if (clr) begin
                    // Flush: drop both entries and the incoming entry. Data holds.
                    r_m_v    <= 1'b0;
                    r_m_ctrl <= '0;
                    r_s_v    <= 1'b0;
                    r_s_ctrl <= '0;
                end else if (!r_m_v) begin
                    if (w_accept) begin
                        r_m_v    <= 1'b1;
                        r_m_ctrl <= in_ctrl;
                        r_m_data <= in_data;
                    end
                end else if (!r_s_v) begin
                    if (w_accept && w_emit) begin
                        r_m_ctrl <= in_ctrl;
                        r_m_data <= in_data;
                    end else if (w_accept) begin
                        r_s_v    <= 1'b1;
                        r_s_ctrl <= in_ctrl;
                        r_s_data <= in_data;
                    end else if (w_emit) begin
                        r_m_v    <= 1'b0;
                    end
                end else if (w_emit) begin
                    // FULL: the skid entry moves forward. Input is blocked here.
                    r_m_ctrl <= r_s_ctrl;
                    r_m_data <= r_s_data;
                    r_s_v    <= 1'b0;
                end
            end
        end else begin : g_noskid
            // Single entry: ready passes through combinationally from downstream.
            assign in_ready = out_ready | ~r_m_v;

            // Single-register occupancy control.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_m_v    <= 1'b0;
                    r_m_ctrl <= '0;
                    r_m_data <= '0;
                end else if (clr) begin
                    r_m_v    <= 1'b0;
                    r_m_ctrl <= '0;
                end else if (w_accept) begin
                    r_m_v    <= 1'b1;
                    r_m_ctrl <= in_ctrl;
                    r_m_data <= in_data;
                end else if (w_emit) begin
                    r_m_v    <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Saturating stall and bubble counters. Only rst clears them; clr does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_m_v && !out_ready && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!r_m_v && out_ready && (r_bubble_cnt != c_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. It instantiates one
//            skid-buffered stage and one passthrough stage, both driven by the
//            same inputs. Each stage is compared against a queue-based model
//            (a FIFO with capacity 2 and capacity 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    localparam int CW = 19;
    localparam int DW = 175;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          rdy0, ov0, rdy1, ov1;
    logic [CW-1:0] oc0, oc1;
    logic [DW-1:0] od0, od1;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   sc0, bc0, sc1, bc1;
    logic [31:0]   m_stall, m_bubble;
`endif

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN_P(1)) dut0 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(sc0), .bubble_cnt(bc0)
`endif
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN_P(0)) dut1 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(sc1), .bubble_cnt(bc1)
`endif
    );

    function automatic logic [DW-1:0] rand_data();
        logic [191:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return w[DW-1:0];
    endfunction

    // Apply inputs, then let combinational outputs settle.
    task automatic set_in(input logic v, input logic c, input logic r,
                          input logic [CW-1:0] ctl, input logic [DW-1:0] dat);
        in_valid  = v;
        clr       = c;
        out_ready = r;
        in_ctrl   = ctl;
        in_data   = dat;
        #1;
    endtask

    // Advance one clock and update the FIFO models from the pre-edge handshakes.
    task automatic tick();
        bit   acc0, em0, acc1, em1;
        ent_t e;
        acc0 = in_valid && (q0.size() < 2);
        em0  = (q0.size() > 0) && out_ready;
        acc1 = in_valid && (out_ready || q1.size() == 0);
        em1  = (q1.size() > 0) && out_ready;
`ifdef PIPE_STAGE_PERF_EN
        if (q0.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (q0.size() == 0 && out_ready && m_bubble != 32'hFFFF_FFFF) m_bubble++;
`endif
        e.c = in_ctrl;
        e.d = in_data;
        @(posedge clk);
        #1;
        if (clr) begin
            q0.delete();
            q1.delete();
        end else begin
            if (em0) void'(q0.pop_front());
            if (acc0) q0.push_back(e);
            if (em1) void'(q1.pop_front());
            if (acc1) q1.push_back(e);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
`ifdef PIPE_STAGE_PERF_EN
        m_stall  = '0;
        m_bubble = '0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 0, 0, '0, '0);
        model_reset();
        checks++;
        if (ov0 !== 1'b0 || oc0 !== '0 || od0 !== '0 || rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_skid: valid=%b ctrl=%h ready=%b data_nz=%b, required 0/0/1/0",
                     ov0, oc0, rdy0, |od0);
        end
        checks++;
        if (ov1 !== 1'b0 || oc1 !== '0 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_noskid: valid=%b ctrl=%h ready=%b, required 0/0/1", ov1, oc1, rdy1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [CW-1:0] ctl;
        for (int k = 1; k <= 4; k++) begin
            ctl = CW'($urandom());
            set_in(1, 0, 1, ctl, DW'(k));
            tick();
            checks++;
            if (ov0 !== 1'b1 || od0 !== DW'(k) || oc0 !== ctl || rdy0 !== 1'b1) begin
                errors++;
                $display("FAIL stream_skid[%0d]: valid=%b data=%0h ctrl=%h ready=%b, required 1/%0h/%h/1",
                         k, ov0, od0[31:0], oc0, rdy0, k, ctl);
            end
            checks++;
            if (ov1 !== 1'b1 || od1 !== DW'(k) || oc1 !== ctl) begin
                errors++;
                $display("FAIL stream_noskid[%0d]: valid=%b data=%0h ctrl=%h, required 1/%0h/%h",
                         k, ov1, od1[31:0], oc1, k, ctl);
            end
        end
        set_in(0, 0, 1, '0, '0);
        tick();
    endtask

    task automatic test_skid_fill();
        set_in(1, 0, 0, 19'h1, DW'(32'hA));
        tick();
        checks++;
        if (rdy0 !== 1'b1 || ov0 !== 1'b1 || od0 !== DW'(32'hA)) begin
            errors++;
            $display("FAIL skid_first: ready=%b valid=%b data=%0h, required 1/1/a", rdy0, ov0, od0[31:0]);
        end
        set_in(1, 0, 0, 19'h2, DW'(32'hB));
        checks++;
        if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL noskid_stall_ready: in_ready=%b, required 0", rdy1);
        end
        tick();
        checks++;
        if (rdy0 !== 1'b0 || ov0 !== 1'b1 || od0 !== DW'(32'hA)) begin
            errors++;
            $display("FAIL skid_full: ready=%b valid=%b data=%0h, required 0/1/a", rdy0, ov0, od0[31:0]);
        end
        set_in(0, 0, 1, '0, '0);
        tick();
        checks++;
        if (rdy0 !== 1'b1 || ov0 !== 1'b1 || od0 !== DW'(32'hB) || oc0 !== 19'h2) begin
            errors++;
            $display("FAIL skid_drain: ready=%b valid=%b data=%0h ctrl=%h, required 1/1/b/2",
                     rdy0, ov0, od0[31:0], oc0);
        end
        checks++;
        if (ov1 !== 1'b0) begin
            errors++;
            $display("FAIL noskid_drain: valid=%b, required 0", ov1);
        end
        tick();
        checks++;
        if (ov0 !== 1'b0 || oc0 !== '0) begin
            errors++;
            $display("FAIL skid_empty: valid=%b ctrl=%h, required 0/0", ov0, oc0);
        end
    endtask

    task automatic test_flush();
        set_in(1, 0, 0, 19'h7FFFF, DW'(32'h1));
        tick();
        set_in(1, 0, 0, 19'h7FFFF, DW'(32'h2));
        tick();
        set_in(1, 1, 0, 19'h7FFFF, DW'(32'h3));
        tick();
        checks++;
        if (ov0 !== 1'b0 || oc0 !== '0 || rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL flush_skid: valid=%b ctrl=%h ready=%b, required 0/0/1", ov0, oc0, rdy0);
        end
        checks++;
        if (ov1 !== 1'b0 || oc1 !== '0) begin
            errors++;
            $display("FAIL flush_noskid: valid=%b ctrl=%h, required 0/0", ov1, oc1);
        end
        set_in(1, 0, 1, 19'h15, DW'(32'h5));
        tick();
        checks++;
        if (ov0 !== 1'b1 || od0 !== DW'(32'h5) || oc0 !== 19'h15) begin
            errors++;
            $display("FAIL flush_after: valid=%b data=%0h ctrl=%h, required 1/5/15", ov0, od0[31:0], oc0);
        end
        set_in(0, 0, 1, '0, '0);
        tick();
    endtask

    task automatic test_async_reset();
        set_in(1, 0, 0, 19'h3, rand_data());
        tick();
        set_in(1, 0, 0, 19'h4, rand_data());
        tick();
        set_in(0, 0, 0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (ov0 !== 1'b0 || oc0 !== '0 || od0 !== '0 || rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b ctrl=%h ready=%b data_nz=%b, required 0/0/1/0",
                     ov0, oc0, rdy0, |od0);
        end
        @(negedge clk);
        rst = 1'b0;
        set_in(1, 0, 1, 19'h9, DW'(32'h77));
        tick();
        checks++;
        if (ov0 !== 1'b1 || od0 !== DW'(32'h77)) begin
            errors++;
            $display("FAIL reset_first_accept: valid=%b data=%0h, required 1/77", ov0, od0[31:0]);
        end
        set_in(0, 0, 1, '0, '0);
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                   1'($urandom_range(0, 2) != 0), CW'($urandom()), rand_data());
            checks++;
            if (rdy0 !== (q0.size() < 2) || rdy1 !== (out_ready || q1.size() == 0)) begin
                errors++;
                $display("FAIL rand_ready[%0d]: ready0=%b ready1=%b, required %b/%b", n, rdy0, rdy1,
                         q0.size() < 2, out_ready || q1.size() == 0);
            end
            tick();
            checks++;
            if (ov0 !== (q0.size() > 0) ||
                (q0.size() > 0 && (oc0 !== q0[0].c || od0 !== q0[0].d)) ||
                (q0.size() == 0 && oc0 !== '0)) begin
                errors++;
                $display("FAIL rand_skid[%0d]: valid=%b ctrl=%h data=%0h, required valid=%b head_ctrl=%h",
                         n, ov0, oc0, od0[31:0], q0.size() > 0, (q0.size() > 0) ? q0[0].c : '0);
            end
            checks++;
            if (ov1 !== (q1.size() > 0) ||
                (q1.size() > 0 && (oc1 !== q1[0].c || od1 !== q1[0].d)) ||
                (q1.size() == 0 && oc1 !== '0)) begin
                errors++;
                $display("FAIL rand_noskid[%0d]: valid=%b ctrl=%h data=%0h, required valid=%b head_ctrl=%h",
                         n, ov1, oc1, od1[31:0], q1.size() > 0, (q1.size() > 0) ? q1[0].c : '0);
            end
`ifdef PIPE_STAGE_PERF_EN
            checks++;
            if (sc0 !== m_stall || bc0 !== m_bubble) begin
                errors++;
                $display("FAIL rand_perf[%0d]: stall=%0d bubble=%0d, required %0d/%0d",
                         n, sc0, bc0, m_stall, m_bubble);
            end
`endif
        end
        set_in(0, 1, 1, '0, '0);
        tick();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        logic [31:0] base;
        set_in(1, 0, 0, 19'h1, rand_data());
        tick();
        set_in(0, 0, 0, '0, '0);
        base = m_stall;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (sc0 !== base + 32'd5) begin
            errors++;
            $display("FAIL perf_stall5: stall_cnt=%0d, required %0d", sc0, base + 32'd5);
        end
        dut0.r_stall_cnt = 32'hFFFF_FFFD;
        m_stall = 32'hFFFF_FFFD;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (sc0 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL perf_saturate: stall_cnt=%h, required ffffffff", sc0);
        end
        base = bc0;
        set_in(0, 1, 0, '0, '0);
        tick();
        checks++;
        if (sc0 !== 32'hFFFF_FFFF || bc0 !== base) begin
            errors++;
            $display("FAIL perf_clr: stall=%h bubble=%0d, required ffffffff/%0d", sc0, bc0, base);
        end
        set_in(0, 0, 1, '0, '0);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_skid_fill();
        test_flush();
        test_async_reset();
        test_random();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
